// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared FFE/LMS fixed-point formats, PAM2 levels and phase encodings
package eq_pkg;

    localparam int EQ_IN_BW    = 11;
    localparam int EQ_OUT_BW   = 9;
    localparam int EQ_COEF_BW  = 9;
    localparam int IN_FRAC     = 7;
    localparam int OUT_FRAC    = 7;
    localparam int COEF_FRAC   = 7;

    // PAM2 decision magnitude: +/-1.0 in S(9,7)
    localparam int DEC_LEVEL   = 128;

    typedef enum logic [1:0] {
        PH_WARM = 2'b00,
        PH_FAST = 2'b01,
        PH_SLOW = 2'b10,
        PH_HOLD = 2'b11
    } phase_t;

endpackage

// File: rtl/lms_tap_update.sv
// rtl/lms_tap_update.sv - one LMS tap: e*x product, step-size shift, saturating accumulator
module lms_tap_update
    import eq_pkg::*;
#(
    parameter int IN_BW    = EQ_IN_BW,
    parameter int ERR_BW   = EQ_OUT_BW + 1,
    parameter int COEF_BW  = EQ_COEF_BW,
    parameter int FRAC_EXT = 12,
    parameter int MU_FAST  = 4,
    parameter int MU_SLOW  = 8,
    parameter logic [COEF_BW+FRAC_EXT-1:0] INIT = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_upd,
    input  logic               i_slow,
    input  logic [ERR_BW-1:0]  i_err,
    input  logic [IN_BW-1:0]   i_x,
    output logic [COEF_BW-1:0] o_coef
);

    localparam int ACC_BW  = COEF_BW + FRAC_EXT;
    localparam int PROD_BW = ERR_BW + IN_BW;
    // product carries IN_FRAC+OUT_FRAC fraction bits; the accumulator carries COEF_FRAC+FRAC_EXT
    localparam int SHL     = COEF_FRAC + FRAC_EXT - IN_FRAC - OUT_FRAC;
    localparam int TERM_BW = PROD_BW + SHL;
    localparam int SUM_BW  = ((TERM_BW > ACC_BW) ? TERM_BW : ACC_BW) + 1;

    localparam logic [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    logic signed [ACC_BW-1:0]  acc;
    logic signed [ACC_BW-1:0]  acc_nxt;
    logic signed [PROD_BW-1:0] err_ext;
    logic signed [PROD_BW-1:0] x_ext;
    logic signed [PROD_BW-1:0] prod;
    logic signed [TERM_BW-1:0] term_shl;
    logic signed [TERM_BW-1:0] term;
    logic signed [SUM_BW-1:0]  sum;
    logic                      ovf;

    assign err_ext  = {{IN_BW{i_err[ERR_BW-1]}}, i_err};
    assign x_ext    = {{ERR_BW{i_x[IN_BW-1]}}, i_x};
    assign prod     = err_ext * x_ext;
    assign term_shl = {prod, {SHL{1'b0}}};
    assign term     = i_slow ? (term_shl >>> MU_SLOW) : (term_shl >>> MU_FAST);

    // Wide add, then clamp to the accumulator range instead of wrapping
    always_comb begin
        sum     = {{(SUM_BW-TERM_BW){term[TERM_BW-1]}}, term}
                + {{(SUM_BW-ACC_BW){acc[ACC_BW-1]}}, acc};
        ovf     = (sum[SUM_BW-1:ACC_BW-1] != {(SUM_BW-ACC_BW+1){sum[SUM_BW-1]}});
        acc_nxt = sum[ACC_BW-1:0];
        if (ovf) begin
            acc_nxt = sum[SUM_BW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator register, loaded only on a gated update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc <= INIT;
        end else if (i_upd) begin
            acc <= acc_nxt;
        end
    end

    assign o_coef = acc[ACC_BW-1 -: COEF_BW];

endmodule

// File: rtl/lms_coef_update.sv
// rtl/lms_coef_update.sv - FFE adaptive coefficient engine: slicer, error, delay line, phase FSM
module lms_coef_update
    import eq_pkg::*;
#(
    parameter int IN_BW     = EQ_IN_BW,
    parameter int OUT_BW    = EQ_OUT_BW,
    parameter int COEF_BW   = EQ_COEF_BW,
    parameter int N_COEF    = 7,
    parameter int DELAY     = 2,
    parameter int FRAC_EXT  = 12,
    parameter int MU_FAST   = 4,
    parameter int MU_SLOW   = 8,
    parameter int FAST_SYMS = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_adapt,
    input  logic [IN_BW-1:0]          i_x,
    input  logic [OUT_BW-1:0]         i_y,
    output logic [COEF_BW*N_COEF-1:0] o_coefs,
    output logic [OUT_BW:0]           o_err,
    output logic                      o_dec,
    output logic [1:0]                o_phase
);

    localparam int ERR_BW  = OUT_BW + 1;
    localparam int DL_LEN  = N_COEF + DELAY;
    localparam int CNT_BW  = $clog2(FAST_SYMS + 1);
    localparam int WARM_BW = $clog2(DL_LEN + 1);
    localparam int ACC_BW  = COEF_BW + FRAC_EXT;
    localparam logic [ACC_BW-1:0] ACC_ONE = ACC_BW'(1) << (COEF_FRAC + FRAC_EXT);

    logic [IN_BW-1:0]   dl [DL_LEN];
    logic               dec;
    logic [ERR_BW-1:0]  dlev;
    logic [ERR_BW-1:0]  err;
    logic               upd;
    logic               is_slow;
    logic               cnt_last;
    phase_t             state;
    phase_t             nxt;
    logic [CNT_BW-1:0]  cnt;
    logic [WARM_BW-1:0] warm_cnt;

    // Slicer and error: e = d - y, widened by one bit so it cannot overflow
    assign dec  = ~i_y[OUT_BW-1];
    assign dlev = dec ? ERR_BW'(DEC_LEVEL) : ERR_BW'(-DEC_LEVEL);
    assign err  = dlev - {i_y[OUT_BW-1], i_y};

    // A symbol is only adapted when the current phase allows it and adapt is still high
    assign upd      = i_en & i_adapt & ((state == PH_FAST) | (state == PH_SLOW));
    assign is_slow  = (state == PH_SLOW);
    assign cnt_last = (cnt == CNT_BW'(FAST_SYMS - 1));

    // Input-sample delay line, advanced with the FFE symbol strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < DL_LEN; j++) begin
                dl[j] <= '0;
            end
        end else if (i_en) begin
            dl[0] <= i_x;
            for (int j = 1; j < DL_LEN; j++) begin
                dl[j] <= dl[j-1];
            end
        end
    end

    // Registered decision and error, captured on each symbol
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= '0;
            o_dec <= 1'b0;
        end else if (i_en) begin
            o_err <= err;
            o_dec <= dec;
        end
    end

    // Phase state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= PH_WARM;
        end else begin
            state <= nxt;
        end
    end

    // Phase next-state: warm-up fill, fast acquire, slow track, freeze
    always_comb begin
        nxt = state;
        case (state)
            PH_WARM: begin
                if (i_en && (warm_cnt == WARM_BW'(DL_LEN - 1))) begin
                    nxt = i_adapt ? PH_FAST : PH_HOLD;
                end
            end
            PH_FAST: begin
                if (!i_adapt) begin
                    nxt = PH_HOLD;
                end else if (upd && cnt_last) begin
                    nxt = PH_SLOW;
                end
            end
            PH_SLOW: begin
                if (!i_adapt) begin
                    nxt = PH_HOLD;
                end
            end
            PH_HOLD: begin
                if (i_adapt) begin
                    nxt = (cnt < CNT_BW'(FAST_SYMS)) ? PH_FAST : PH_SLOW;
                end
            end
            default: nxt = PH_WARM;
        endcase
    end

    // Warm-up symbol count and adapting-symbol count (saturates at FAST_SYMS)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            warm_cnt <= '0;
            cnt      <= '0;
        end else begin
            if (i_en && (state == PH_WARM)) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            if (upd && (cnt != CNT_BW'(FAST_SYMS))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_phase = state;

    for (genvar k = 0; k < N_COEF; k++) begin : g_tap
        lms_tap_update #(
            .IN_BW    (IN_BW),
            .ERR_BW   (ERR_BW),
            .COEF_BW  (COEF_BW),
            .FRAC_EXT (FRAC_EXT),
            .MU_FAST  (MU_FAST),
            .MU_SLOW  (MU_SLOW),
            .INIT     ((k == N_COEF / 2) ? ACC_ONE : '0)
        ) u_tap (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_upd  (upd),
            .i_slow (is_slow),
            .i_err  (err),
            .i_x    (dl[k+DELAY]),
            .o_coef (o_coefs[k*COEF_BW +: COEF_BW])
        );
    end

endmodule

// File: tb/tb_lms_coef_update.sv
// tb/tb_lms_coef_update.sv - self-checking bench for lms_coef_update
module tb_lms_coef_update;

    localparam int FS = 16;
    localparam logic [62:0] RESET_COEFS = 63'(128) << 27;
    localparam logic [62:0] UPD_COEFS   = 63'(132) << 27;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic        i_adapt;
    logic [10:0] i_x;
    logic [8:0]  i_y;
    logic [62:0] o_coefs;
    logic [9:0]  o_err;
    logic        o_dec;
    logic [1:0]  o_phase;

    lms_coef_update #(.FAST_SYMS(FS)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_adapt (i_adapt),
        .i_x     (i_x),
        .i_y     (i_y),
        .o_coefs (o_coefs),
        .o_err   (o_err),
        .o_dec   (o_dec),
        .o_phase (o_phase)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [62:0] coefs;
        logic [9:0]  err;
        logic        dec;
        logic [1:0]  phase;
    } exp_t;

    typedef struct {
        int          y;
        logic [9:0]  err;
        logic        dec;
    } vec_t;

    exp_t   sbq[$];
    vec_t   vt[6];
    int     n_chk = 0;
    int     n_err = 0;

    int     m_dl[9];
    longint m_acc[7];
    int     m_phase, m_warm, m_cnt, m_err;
    bit     m_dec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [62:0] model_coefs();
        logic [62:0] b;
        longint      c;
        b = '0;
        for (int k = 0; k < 7; k++) begin
            c = m_acc[k] >>> 12;
            b[k*9 +: 9] = c[8:0];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 9; j++) m_dl[j] = 0;
        for (int k = 0; k < 7; k++) m_acc[k] = (k == 3) ? (longint'(1) << 19) : 0;
        m_phase = 0; m_warm = 0; m_cnt = 0; m_err = 0; m_dec = 0;
    endtask

    task automatic model_step(input bit en, input bit adapt, input int x, input int y);
        int     d, e, mu, nph;
        bit     upd;
        longint t, s;
        upd = en && adapt && (m_phase == 1 || m_phase == 2);
        nph = m_phase;
        case (m_phase)
            0: if (en && m_warm == 8) nph = adapt ? 1 : 3;
            1: if (!adapt) nph = 3; else if (upd && m_cnt + 1 == FS) nph = 2;
            2: if (!adapt) nph = 3;
            default: if (adapt) nph = (m_cnt < FS) ? 1 : 2;
        endcase
        d = (y >= 0) ? 128 : -128;
        e = d - y;
        if (upd) begin
            mu = (m_phase == 2) ? 8 : 4;
            for (int k = 0; k < 7; k++) begin
                t = (longint'(e) * m_dl[k+2] * 32) >>> mu;
                s = m_acc[k] + t;
                if (s > (longint'(1) << 20) - 1) s = (longint'(1) << 20) - 1;
                if (s < -(longint'(1) << 20)) s = -(longint'(1) << 20);
                m_acc[k] = s;
            end
            if (m_cnt < FS) m_cnt++;
        end
        if (en && m_phase == 0) m_warm++;
        if (en) begin
            m_err = e;
            m_dec = (y >= 0);
            for (int j = 8; j > 0; j--) m_dl[j] = m_dl[j-1];
            m_dl[0] = x;
        end
        m_phase = nph;
    endtask

    task automatic step(input bit en, input bit adapt, input int x, input int y);
        exp_t ex;
        exp_t got;
        @(negedge i_clk);
        i_en = en; i_adapt = adapt; i_x = x[10:0]; i_y = y[8:0];
        model_step(en, adapt, x, y);
        ex.coefs = model_coefs();
        ex.err   = m_err[9:0];
        ex.dec   = m_dec;
        ex.phase = m_phase[1:0];
        sbq.push_back(ex);
        @(posedge i_clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard empty", 64'd0, 64'd1);
        end else begin
            got = sbq.pop_front();
            chk("coefs", 64'(o_coefs), 64'(got.coefs));
            chk("err", 64'(o_err), 64'(got.err));
            chk("dec", 64'(o_dec), 64'(got.dec));
            chk("phase", 64'(o_phase), 64'(got.phase));
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge i_clk);
        i_rst = 1'b1; i_en = 1'b1; i_adapt = 1'b1; i_x = 11'd77; i_y = 9'd33;
        repeat (cycles) @(posedge i_clk);
        #1;
        model_reset();
        chk("reset coefs", 64'(o_coefs), 64'(RESET_COEFS));
        chk("reset phase", 64'(o_phase), 64'd0);
        chk("reset err", 64'(o_err), 64'd0);
        chk("reset dec", 64'(o_dec), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0; i_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [62:0] frozen;

        vt[0] = '{y: -64,  err: 10'h3C0, dec: 1'b0};
        vt[1] = '{y: 0,    err: 10'd128, dec: 1'b1};
        vt[2] = '{y: 255,  err: 10'h381, dec: 1'b1};
        vt[3] = '{y: -256, err: 10'd128, dec: 1'b0};
        vt[4] = '{y: -1,   err: 10'h381, dec: 1'b0};
        vt[5] = '{y: 127,  err: 10'd1,   dec: 1'b1};

        i_rst = 1'b1; i_en = 1'b0; i_adapt = 1'b0; i_x = '0; i_y = '0;
        do_reset(2);

        // Warm-up: nine strobes fill the delay line; +1.0 placed so it lands on tap 3
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, (i == 3) ? 128 : 0, 0);
            chk("warm phase", 64'(o_phase), (i < 8) ? 64'd0 : 64'd1);
            chk("warm coefs", 64'(o_coefs), 64'(RESET_COEFS));
        end

        // Single FAST update: e = +0.5, x = +1.0 on tap 3
        step(1'b1, 1'b1, 0, 64);
        chk("single err", 64'(o_err), 64'd64);
        chk("single dec", 64'(o_dec), 64'd1);
        chk("single coefs", 64'(o_coefs), 64'(UPD_COEFS));

        // Slicer/error table
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 0, vt[i].y);
            chk("table err", 64'(o_err), 64'(vt[i].err));
            chk("table dec", 64'(o_dec), 64'(vt[i].dec));
        end

        // Idle cycles: no strobe, nothing moves
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 100, 50);

        // Freeze with random outputs
        frozen = model_coefs();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 0, int'($urandom_range(511)) - 256);
        chk("freeze phase", 64'(o_phase), 64'd3);
        chk("freeze coefs", 64'(o_coefs), 64'(frozen));
        step(1'b1, 1'b1, 0, 10);
        chk("unfreeze phase", 64'(o_phase), 64'd1);

        // Constant e = +1.0, x = +1.0 until FAST_SYMS updates switch to SLOW
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 128, 0);
        chk("slow phase", 64'(o_phase), 64'd2);

        // Keep driving until tap 0 saturates, then confirm it holds
        for (int i = 0; i < 700; i++) step(1'b1, 1'b1, 128, 0);
        chk("c0 sat", 64'(o_coefs[8:0]), 64'h0FF);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 128, 0);
        chk("c0 no wrap", 64'(o_coefs[8:0]), 64'h0FF);

        // Reset while in SLOW
        do_reset(1);
        step(1'b1, 1'b1, 0, 0);
        chk("post reset warm", 64'(o_phase), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
